// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_ADDR_HI = 4'd1,
        ST_ADDR_LO = 4'd2,
        ST_CNT_HI  = 4'd3,
        ST_CNT_LO  = 4'd4,
        ST_DATA_HI = 4'd5,
        ST_DATA_LO = 4'd6,
        ST_WRITE   = 4'd7,
        ST_CHECK   = 4'd8,
        ST_DONE    = 4'd9,
        ST_ERROR   = 4'd10
    } state_t;

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_ALIGN = 3'd1;
    localparam logic [2:0] ERR_WRAP  = 3'd2;
    localparam logic [2:0] ERR_CSUM  = 3'd3;
    localparam logic [2:0] ERR_MEM   = 3'd4;

    localparam logic [15:0] MAX_ADDR = 16'hFFFE;

    function automatic logic state_accepts_bytes(input state_t s);
        return s inside {ST_ADDR_HI, ST_ADDR_LO, ST_CNT_HI, ST_CNT_LO,
                         ST_DATA_HI, ST_DATA_LO, ST_CHECK};
    endfunction

endpackage

// File: rtl/imem_loader_byte_pair_assembler.sv
// Joins big-endian byte pairs into 16-bit header and data words.
module byte_pair_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  byte_i,
    input  logic        take_i,
    input  logic        lo_i,
    input  logic        data_sel_i,
    output logic [15:0] hdr_o,
    output logic [15:0] data_o,
    output logic [15:0] pair_o
);

    logic [7:0]  hi_q;
    logic [15:0] hdr_q;
    logic [15:0] data_q;

    // Word registers only change on the low byte, so they never show a half-updated value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q   <= 8'h00;
            hdr_q  <= 16'h0000;
            data_q <= 16'h0000;
        end else if (take_i) begin
            if (!lo_i) begin
                hi_q <= byte_i;
            end else if (data_sel_i) begin
                data_q <= {hi_q, byte_i};
            end else begin
                hdr_q <= {hi_q, byte_i};
            end
        end
    end

    assign hdr_o  = hdr_q;
    assign data_o = data_q;
    assign pair_o = {hi_q, byte_i};

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream program loader driving the instruction memory write port.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_enable,
    output logic              mem_wr,
    input  logic              mem_err,
    output logic              core_hold,
    output logic              done,
    output logic [2:0]        err_code
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [7:0]        csum_q, csum_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_wr_q, mem_wr_d;
    logic              done_q, done_d;
    logic              hold_q, hold_d;
    logic [2:0]        err_q, err_d;

    logic        accept;
    logic [15:0] hdr_w, data_w, pair_w;

    assign in_ready = state_accepts_bytes(state_q);
    assign accept   = in_valid && in_ready;

    byte_pair_assembler u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_i     (in_data),
        .take_i     (accept && (state_q != ST_CHECK)),
        .lo_i       (state_q inside {ST_ADDR_LO, ST_CNT_LO, ST_DATA_LO}),
        .data_sel_i (state_q inside {ST_DATA_HI, ST_DATA_LO}),
        .hdr_o      (hdr_w),
        .data_o     (data_w),
        .pair_o     (pair_w)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        csum_d     = csum_q;
        mem_addr_d = mem_addr_q;
        mem_wr_d   = 1'b0;
        done_d     = done_q;
        hold_d     = hold_q;
        err_d      = err_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d = ST_ADDR_HI;
                    done_d  = 1'b0;
                    err_d   = ERR_NONE;
                    csum_d  = 8'h00;
                    hold_d  = 1'b1;
                end
            end
            ST_ADDR_HI: if (accept) state_d = ST_ADDR_LO;
            ST_ADDR_LO: if (accept) state_d = ST_CNT_HI;
            ST_CNT_HI: begin
                // The completed start address is still in the header register this cycle.
                if (accept) begin
                    addr_d  = ADDR_W'(hdr_w);
                    state_d = ST_CNT_LO;
                end
            end
            ST_CNT_LO: begin
                if (accept) begin
                    cnt_d = pair_w;
                    if (addr_q[0]) begin
                        state_d = ST_ERROR;
                        err_d   = ERR_ALIGN;
                    end else if (pair_w == 16'd0) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_DATA_HI;
                    end
                end
            end
            ST_DATA_HI: begin
                if (accept) begin
                    csum_d  = csum_q ^ in_data;
                    state_d = ST_DATA_LO;
                end
            end
            ST_DATA_LO: begin
                if (accept) begin
                    csum_d     = csum_q ^ in_data;
                    mem_addr_d = addr_q;
                    mem_wr_d   = 1'b1;
                    state_d    = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (mem_err) begin
                    state_d = ST_ERROR;
                    err_d   = ERR_MEM;
                end else if (cnt_q == 16'd1) begin
                    state_d = ST_CHECK;
                end else if (addr_q == ADDR_W'(MAX_ADDR)) begin
                    state_d = ST_ERROR;
                    err_d   = ERR_WRAP;
                end else begin
                    addr_d  = addr_q + ADDR_W'(2);
                    cnt_d   = cnt_q - 16'd1;
                    state_d = ST_DATA_HI;
                end
            end
            ST_CHECK: begin
                if (accept) begin
                    if (in_data == csum_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = ST_ERROR;
                        err_d   = ERR_CSUM;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            cnt_q      <= 16'd0;
            csum_q     <= 8'h00;
            mem_addr_q <= '0;
            mem_wr_q   <= 1'b0;
            done_q     <= 1'b0;
            hold_q     <= 1'b1;
            err_q      <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            csum_q     <= csum_d;
            mem_addr_q <= mem_addr_d;
            mem_wr_q   <= mem_wr_d;
            done_q     <= done_d;
            hold_q     <= hold_d;
            err_q      <= err_d;
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_data_in = DATA_W'(data_w);
    assign mem_wr      = mem_wr_q;
    assign mem_enable  = mem_wr_q;
    assign core_hold   = hold_q;
    assign done        = done_q;
    assign err_code    = err_q;

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that acts as the write side of the instruction memory port. It receives a framed byte stream, assembles big-endian 16-bit instructions and writes them into instruction memory at consecutive even addresses. While a load is in progress it holds the fetch stage in reset. It sits between an external byte source (UART/debug bridge) and the instruction memory write port, alongside the fetch stage.

## Interface
Parameters:
- `ADDR_W`, 16: instruction memory address width, in bytes.
- `DATA_W`, 16: instruction width. Fixed at 16, two bytes per word.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a load. Accepted only in IDLE, DONE or ERROR.
- `in_valid`  in  1  byte-stream valid.
- `in_data`  in  8  byte-stream data.
- `in_ready`  out  1  byte-stream ready. A byte transfers when `in_valid && in_ready`.
- `mem_addr`  out  ADDR_W  write address (byte address, always even).
- `mem_data_in`  out  DATA_W  write data.
- `mem_enable`  out  1  memory enable.
- `mem_wr`  out  1  memory write strobe.
- `mem_err`  in  1  memory error, sampled in the write cycle.
- `core_hold`  out  1  holds fetch/core in reset while high.
- `done`  out  1  load completed successfully. Level output.
- `err_code`  out  3  error status. Values are defined in the package.

## Operation
Frame format, in byte order:
1. Start address: high byte, then low byte.
2. Word count N: high byte, then low byte.
3. 2N payload bytes: for each word, the high byte, then the low byte.
4. One checksum byte: the XOR of all payload bytes.

States:
- **IDLE**: `start` → ADDR_HI.
- **ADDR_HI**, **ADDR_LO**: on each accepted byte, shift it into the address register.
- **CNT_HI**, **CNT_LO**: on each accepted byte, shift it into the count register.
- **Leaving CNT_LO**: check in this order.
  - Address bit 0 set → ERROR with ERR_ALIGN.
  - Otherwise, N == 0 → CHECK.
  - Otherwise → DATA_HI.
- **DATA_HI**, **DATA_LO**: accept the high byte, then the low byte, into the word register. Fold each byte into the running XOR. DATA_LO → WRITE.
- **WRITE**: drive `mem_enable = mem_wr = 1` with the current address and word, for exactly one cycle. Then check in this order.
  - `mem_err` high → ERROR with ERR_MEM.
  - Otherwise, this was the last word → CHECK.
  - Otherwise, address == 0xFFFE (max even address) → ERROR with ERR_WRAP. The address never wraps.
  - Otherwise, address += 2, decrement the remaining count → DATA_HI.
- **CHECK**: accept one byte.
  - It equals the running XOR → DONE.
  - It differs → ERROR with ERR_CSUM.
- **DONE**: `done = 1`, `core_hold = 0`, `in_ready = 0`. `start` → ADDR_HI.
- **ERROR**: `core_hold` stays 1, `err_code` holds its value. `start` → ADDR_HI.

Load-start rules:
- An accepted `start` clears `done`, `err_code` and the running XOR, and sets `core_hold`.
- `start` in any other state is ignored.

Output and handshake rules:
- `in_ready` is 1 only in ADDR_HI/LO, CNT_HI/LO, DATA_HI/LO and CHECK. It is 0 in WRITE, so write back-pressure is one cycle per word.
- Bytes presented while `in_ready` is 0 are not consumed. The source must hold them.
- `mem_wr` and `mem_enable` are 0 outside WRITE. Outside WRITE, `mem_addr` and `mem_data_in` hold their last values.

## Timing
Reset values:
- State is IDLE.
- `core_hold` = 1. The core is held until the first successful load.
- `done` = 0, `err_code` = ERR_NONE, `in_ready` = 0, `mem_wr` = 0, `mem_enable` = 0, `mem_addr` = 0, `mem_data_in` = 0.

Latency:
- `start` → `in_ready` = 1 on the next cycle.
- Byte acceptance in a state → next state on the next cycle.
- DATA_LO accept → WRITE strobe on the next cycle.
- Final checksum byte accept → `done` or `err_code` valid on the next cycle, and `core_hold` low on the next cycle for DONE.
- Minimum load time is 4 + 3N + 1 cycles, with `in_valid` held high.

Reset mid-load: asynchronous return to the reset values. A partially written memory image is left as is.

## Structure
- Package `imem_loader_pkg`:
  - The state enum.
  - Error codes: ERR_NONE = 0, ERR_ALIGN = 1, ERR_WRAP = 2, ERR_CSUM = 3, ERR_MEM = 4.
  - Constant `MAX_ADDR = 16'hFFFE`.
- One sub-module, `byte_pair_assembler`: takes the shared HI/LO byte phase and produces the 16-bit header and data registers.
- The FSM, counters and checksum stay in `imem_loader`.

## Test plan
- **Nominal load.** Stimulus: `start`; bytes 00 10 00 02 12 34 AB CD, checksum 12^34^AB^CD = 40. Required: writes (0x0010, 0x1234) then (0x0012, 0xABCD); `done` = 1, `core_hold` = 0, `err_code` = 0.
- **Checksum fail.** Stimulus: the same frame with checksum 41. Required: both writes occur, `err_code` = 3, `core_hold` stays 1, `done` = 0.
- **Misaligned address.** Stimulus: address 00 11, count 00 01. Required: no write, `err_code` = 1, `in_ready` = 0 after CNT_LO.
- **Wrap and zero count.**
  - Stimulus: address FF FE, count 00 02, first word 0x1111. Required: one write at 0xFFFE, then `err_code` = 2.
  - Stimulus: count 00 00 with checksum 00. Required: `done` with no writes.
- **Memory error and restart.** Stimulus: `mem_err` = 1 on the first WRITE. Required: `err_code` = 4. Then a new `start` plus the nominal frame gives `done` = 1 with `err_code` cleared.
- **Stall and reset.**
  - Stimulus: random `in_valid` gaps. Required: identical write sequence to the nominal load.
  - Stimulus: `rst_n` low during DATA_LO. Required: all outputs at reset values immediately; a partial frame after reset is ignored until `start`.
